// File: rtl/qmult_seq.sv
// Sequential signed fixed-point multiplier in Q-format.
// Operands are converted to sign + magnitude on acceptance. The magnitude
// product is built with N shift-add steps, one multiplier bit per cycle.
// The product is then scaled, optionally rounded, and range-checked. Finally
// it is either clamped or wrapped to N bits.
module qmult_seq #(
    parameter int Q     = 12,
    parameter int N     = 16,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q_result,
    output logic         overflow
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    // Largest positive magnitude and largest negative magnitude, held in 2N bits.
    localparam logic [2*N-1:0] LIM_POS = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [2*N-1:0] LIM_NEG = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           sign_q;
    logic [2*N-1:0] mcand_q;
    logic [N-1:0]   mplier_q;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   q_result_q, q_result_d;
    logic           overflow_q, overflow_d;

    logic           accept;
    logic           last_step;
    logic [N-1:0]   opnd     [2];
    logic [N-1:0]   opnd_mag [2];
    logic [2*N-1:0] round_add;
    logic [2*N-1:0] mag_scaled;
    logic           ovf_now;
    logic [N-1:0]   mag_low;
    logic [N-1:0]   signed_low;

    assign opnd[0] = a;
    assign opnd[1] = b;

    // Magnitude of each operand. The N-bit unsigned result keeps
    // |-2^(N-1)| = 2^(N-1) exactly.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            assign opnd_mag[gi] = opnd[gi][N-1] ? (~opnd[gi] + 1'b1) : opnd[gi];
        end
    endgenerate

    assign accept    = in_valid && in_ready;
    assign last_step = (state_q == CALC) && (cnt_q == CW'(N-1));

    // Next-state logic and the handshake outputs for the three-state controller.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = in_valid ? CALC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset overrides any accept or retire at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-half-away-from-zero adds the first discarded bit to the magnitude.
    generate
        if (ROUND != 0 && Q > 0) begin : g_round
            assign round_add = {{(2*N-1){1'b0}}, acc_d[Q-1]};
        end else begin : g_trunc
            assign round_add = '0;
        end
    endgenerate

    // One shift-add step, plus scaling and range check of the completed product.
    always_comb begin
        acc_d      = acc_q + (mplier_q[0] ? mcand_q : '0);
        mag_scaled = (acc_d >> Q) + round_add;
        ovf_now    = mag_scaled > (sign_q ? LIM_NEG : LIM_POS);
        mag_low    = mag_scaled[N-1:0];
        signed_low = sign_q ? (~mag_low + 1'b1) : mag_low;
        overflow_d = ovf_now;
    end

    // Clamp to the signed extremes, or keep the wrapped low N bits.
    generate
        if (SAT != 0) begin : g_sat
            always_comb begin
                q_result_d = signed_low;
                if (ovf_now) begin
                    q_result_d = sign_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                end
            end
        end else begin : g_wrap
            always_comb begin
                q_result_d = signed_low;
            end
        end
    endgenerate

    // Datapath: capture operands on accept, step while calculating, and load the result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q     <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            q_result_q <= '0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            sign_q   <= a[N-1] ^ b[N-1];
            mcand_q  <= {{N{1'b0}}, opnd_mag[0]};
            mplier_q <= opnd_mag[1];
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == CALC) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last_step) begin
                q_result_q <= q_result_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign q_result = q_result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_qmult_seq.sv
// Randomized and directed bench for qmult_seq with N=16 and Q=12.
// Three instances share the same stimulus:
//   - truncate and clamp
//   - round and clamp
//   - truncate and wrap
// An arithmetic reference tracks expected handshakes and results.
module tb_qmult_seq;

    localparam int N = 16;
    localparam int Q = 12;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;

    logic        rdy [3];
    logic        vld [3];
    logic [15:0] dq  [3];
    logic        dov [3];

    int checks = 0;
    int errors = 0;

    // Reference state, updated once per clock edge from the stimulus only.
    bit          live    = 0;
    bit          m_busy  = 0;
    bit          m_valid = 0;
    bit          m_rdy;
    int          m_cnt   = 0;
    logic [15:0] exp_q  [3];
    logic        exp_o  [3];
    logic [15:0] pend_q [3];
    logic        pend_o [3];
    int          rnd_cfg [3] = '{0, 1, 0};
    int          sat_cfg [3] = '{1, 1, 0};

    qmult_seq #(.Q(Q), .N(N), .ROUND(0), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(op_a), .b(op_b), .out_valid(vld[0]), .out_ready(out_ready),
        .q_result(dq[0]), .overflow(dov[0])
    );

    qmult_seq #(.Q(Q), .N(N), .ROUND(1), .SAT(1)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(op_a), .b(op_b), .out_valid(vld[1]), .out_ready(out_ready),
        .q_result(dq[1]), .overflow(dov[1])
    );

    qmult_seq #(.Q(Q), .N(N), .ROUND(0), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(op_a), .b(op_b), .out_valid(vld[2]), .out_ready(out_ready),
        .q_result(dq[2]), .overflow(dov[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Product from plain signed arithmetic, returned as {overflow, q_result}.
    function automatic logic [16:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input int rnd, input int sat);
        longint sx  = $signed(x);
        longint sy  = $signed(y);
        longint p   = sx * sy;
        bit     neg = x[15] ^ y[15];
        longint mag = (p < 0) ? -p : p;
        longint m   = mag >> Q;
        longint lim;
        longint v;
        logic   ovf;
        logic [15:0] q;
        if (rnd != 0) m = m + ((mag >> (Q - 1)) & 64'sd1);
        lim = neg ? 64'sd32768 : 64'sd32767;
        ovf = (m > lim);
        if (sat != 0 && ovf) begin
            q = neg ? 16'h8000 : 16'h7FFF;
        end else begin
            v = neg ? -m : m;
            q = v[15:0];
        end
        return {ovf, q};
    endfunction

    // Reference: accepted pair matures N edges later; a result stays until out_ready.
    always @(posedge clk) begin
        if (rst) begin
            live    = 1;
            m_busy  = 0;
            m_valid = 0;
            m_cnt   = 0;
            for (int i = 0; i < 3; i++) begin
                exp_q[i] = 16'h0000;
                exp_o[i] = 1'b0;
            end
        end else if (live) begin
            m_rdy = !m_busy && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy  = 0;
                    m_valid = 1;
                    for (int i = 0; i < 3; i++) begin
                        exp_q[i] = pend_q[i];
                        exp_o[i] = pend_o[i];
                    end
                end
            end
            if (in_valid && m_rdy) begin
                m_busy = 1;
                m_cnt  = N;
                for (int i = 0; i < 3; i++) begin
                    logic [16:0] r;
                    r = ref_mul(op_a, op_b, rnd_cfg[i], sat_cfg[i]);
                    pend_q[i] = r[15:0];
                    pend_o[i] = r[16];
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the reference.
    always @(negedge clk) begin
        if (live && !rst) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("in_ready[%0d]", i), {31'd0, rdy[i]},
                    {31'd0, (!m_busy && (!m_valid || out_ready))});
                chk($sformatf("out_valid[%0d]", i), {31'd0, vld[i]}, {31'd0, m_valid});
                chk($sformatf("q_result[%0d]", i), {16'd0, dq[i]}, {16'd0, exp_q[i]});
                chk($sformatf("overflow[%0d]", i), {31'd0, dov[i]}, {31'd0, exp_o[i]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the result after an accept, with a bounded budget; returns cycles waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (!vld[0] && n < 40) begin
            tick();
            n++;
        end
    endtask

    // One directed operation with hand-computed expectations per instance.
    task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] q0, input logic o0,
                         input logic [15:0] q1, input logic o1,
                         input logic [15:0] q2, input logic o2);
        int          n;
        logic [16:0] r;
        logic [15:0] eq [3];
        logic        eo [3];
        eq[0] = q0; eq[1] = q1; eq[2] = q2;
        eo[0] = o0; eo[1] = o1; eo[2] = o2;
        for (int i = 0; i < 3; i++) begin
            r = ref_mul(x, y, rnd_cfg[i], sat_cfg[i]);
            chk($sformatf("%s model_q[%0d]", tag, i), {16'd0, r[15:0]}, {16'd0, eq[i]});
            chk($sformatf("%s model_ovf[%0d]", tag, i), {31'd0, r[16]}, {31'd0, eo[i]});
        end
        op_a      = x;
        op_b      = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, " idle_ready"}, {31'd0, rdy[0]}, 32'd1);
        tick();
        in_valid = 1'b0;
        op_a     = 16'h7FFF;
        op_b     = 16'h7FFF;
        wait_valid(n);
        chk({tag, " latency"}, n, 32'd16);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s q[%0d]", tag, i), {16'd0, dq[i]}, {16'd0, eq[i]});
            chk($sformatf("%s ovf[%0d]", tag, i), {31'd0, dov[i]}, {31'd0, eo[i]});
        end
        $display("op %s a=%h b=%h q=%h/%h/%h ovf=%b%b%b", tag, x, y,
                 dq[0], dq[1], dq[2], dov[0], dov[1], dov[2]);
        tick();
    endtask

    function automatic logic [15:0] pick();
        int unsigned r = $urandom;
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return {8'h00, r[7:0]};
            4:       return {8'hFF, r[7:0]};
            default: return r[15:0];
        endcase
    endfunction

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = 16'h0000;
        op_b      = 16'h0000;
        repeat (3) tick();
        rst = 1'b0;
        #2;
        chk("reset in_ready", {31'd0, rdy[0]}, 32'd1);
        chk("reset out_valid", {31'd0, vld[0]}, 32'd0);
        chk("reset q_result", {16'd0, dq[0]}, 32'd0);
        chk("reset overflow", {31'd0, dov[0]}, 32'd0);
        tick();

        do_op("p1.5x2", 16'h1800, 16'h2000, 16'h3000, 0, 16'h3000, 0, 16'h3000, 0);
        do_op("n1.5x2", 16'hE800, 16'h2000, 16'hD000, 0, 16'hD000, 0, 16'hD000, 0);
        do_op("7x2", 16'h7000, 16'h2000, 16'h7FFF, 1, 16'h7FFF, 1, 16'hE000, 1);
        do_op("min2", 16'h8000, 16'h8000, 16'h7FFF, 1, 16'h7FFF, 1, 16'h0000, 1);
        do_op("tiny", 16'h0001, 16'h0800, 16'h0000, 0, 16'h0001, 0, 16'h0000, 0);
        do_op("zeroneg", 16'h0000, 16'h8000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);

        // Back-pressure: hold the result, then retire and accept at one edge.
        op_a      = 16'h1800;
        op_b      = 16'hE000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        chk("stall latency", n, 32'd16);
        for (int k = 0; k < 5; k++) begin
            chk("stall q", {16'd0, dq[0]}, 32'h0000D000);
            chk("stall in_ready", {31'd0, rdy[0]}, 32'd0);
            chk("stall out_valid", {31'd0, vld[0]}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_a      = 16'h0800;
        op_b      = 16'h0800;
        #1;
        chk("retire in_ready", {31'd0, rdy[0]}, 32'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        chk("b2b latency", n, 32'd16);
        chk("b2b q", {16'd0, dq[0]}, 32'h00000400);
        $display("op stall/b2b q=%h ovf=%b", dq[0], dov[0]);
        tick();

        // Reset in the middle of a calculation.
        op_a     = 16'h1800;
        op_b     = 16'h2000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", {31'd0, rdy[0]}, 32'd1);
        chk("abort out_valid", {31'd0, vld[0]}, 32'd0);
        chk("abort q_result", {16'd0, dq[0]}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            chk("abort no_valid", {31'd0, vld[0]}, 32'd0);
            tick();
        end
        $display("op abort q=%h valid=%b", dq[0], vld[0]);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            rst       = (!rst && $urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            op_a      = pick();
            op_b      = pick();
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
